chacha_stream_xor: RTL

CHACHA_STREAM_XOR -- requirements
Module: chacha_stream_xor

---
 rtl/chacha_pkg.sv | 26 ++
 rtl/chacha_block.sv | 83 ++++++++
 rtl/chacha_stream_xor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha constants, controller state encoding and small word helpers.
package chacha_pkg;

   localparam logic [0:3][31:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

   localparam int unsigned WORD_IDX_W = 4;

   // Word 0 occupies the most significant 32 bits of a block.
   typedef logic [0:15][31:0] blk_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GEN    = 2'd1,
      STREAM = 2'd2,
      ERR    = 2'd3
   } state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] w, input int unsigned n);
      return (w << n) | (w >> (32 - n));
   endfunction

endpackage

// File: rtl/chacha_block.sv
// Iterative ChaCha block function: one round per cycle, feed-forward add on the last round.
module chacha_block
   import chacha_pkg::*;
#(
   parameter int NUM_ROUNDS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  blk_t state_in,
   output logic done,
   output blk_t block_out
);

   localparam int RND_W = $clog2(NUM_ROUNDS) + 1;

   blk_t             init_q;
   blk_t             work_q;
   blk_t             col_d;
   blk_t             diag_d;
   blk_t             round_d;
   blk_t             final_d;
   logic [RND_W-1:0] rnd_q;
   logic             running_q;

   function automatic logic [0:3][31:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                                input logic [31:0] c_in, input logic [31:0] d_in);
      logic [31:0] a, b, c, d;
      a = a_in;
      b = b_in;
      c = c_in;
      d = d_in;
      a = a + b;  d = rotl32(d ^ a, 16);
      c = c + d;  b = rotl32(b ^ c, 12);
      a = a + b;  d = rotl32(d ^ a, 8);
      c = c + d;  b = rotl32(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // Even rounds mix columns, odd rounds mix diagonals.
   always_comb begin
      col_d  = work_q;
      diag_d = work_q;
      for (int unsigned i = 0; i < 4; i++) begin
         {col_d[i], col_d[4+i], col_d[8+i], col_d[12+i]} =
            quarter(work_q[i], work_q[4+i], work_q[8+i], work_q[12+i]);
         {diag_d[i], diag_d[4+((i+1)%4)], diag_d[8+((i+2)%4)], diag_d[12+((i+3)%4)]} =
            quarter(work_q[i], work_q[4+((i+1)%4)], work_q[8+((i+2)%4)], work_q[12+((i+3)%4)]);
      end
      round_d = rnd_q[0] ? diag_d : col_d;
      for (int unsigned i = 0; i < 16; i++) begin
         final_d[i] = round_d[i] + init_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         init_q    <= '0;
         work_q    <= '0;
         rnd_q     <= '0;
         running_q <= 1'b0;
         done      <= 1'b0;
         block_out <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            init_q    <= state_in;
            work_q    <= state_in;
            rnd_q     <= '0;
            running_q <= 1'b1;
         end else if (running_q) begin
            work_q <= round_d;
            rnd_q  <= rnd_q + 1'b1;
            if (rnd_q == RND_W'(NUM_ROUNDS - 1)) begin
               running_q <= 1'b0;
               done      <= 1'b1;
               block_out <= final_d;
            end
         end
      end
   end

endmodule

// File: rtl/chacha_stream_xor.sv
// Streams 32-bit words XORed with ChaCha keystream, regenerating a block every 16 words.
module chacha_stream_xor
   import chacha_pkg::*;
#(
   parameter int NUM_ROUNDS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_load,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  counter_init,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         out_last,
   output logic         busy,
   output logic         err
);

   state_t                state;
   logic [255:0]          key_q;
   logic [95:0]           nonce_q;
   logic [31:0]           ctr_q;
   logic                  last_blk_q;
   blk_t                  ks_q;
   logic [WORD_IDX_W-1:0] word_idx;
   logic                  start_q;
   blk_t                  core_in;
   blk_t                  core_out;
   logic                  core_done;
   logic                  accept;
   logic                  cfg_take;

   always_comb begin
      core_in = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         core_in[i] = SIGMA[i];
      end
      for (int unsigned i = 0; i < 8; i++) begin
         core_in[4+i] = bswap32(key_q[255-32*i -: 32]);
      end
      core_in[12] = ctr_q;
      for (int unsigned i = 0; i < 3; i++) begin
         core_in[13+i] = bswap32(nonce_q[95-32*i -: 32]);
      end
   end

   assign in_ready = (state == STREAM) && (!out_valid || out_ready);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign cfg_take = cfg_load && (state != GEN);

   chacha_block #(
      .NUM_ROUNDS(NUM_ROUNDS)
   ) u_core (
      .clk      (clk),
      .rst_n    (~rst),
      .start    (start_q),
      .state_in (core_in),
      .done     (core_done),
      .block_out(core_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         key_q      <= '0;
         nonce_q    <= '0;
         ctr_q      <= '0;
         last_blk_q <= 1'b0;
         ks_q       <= '0;
         word_idx   <= '0;
         start_q    <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         err        <= 1'b0;
      end else begin
         start_q <= 1'b0;

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            out_data  <= in_data ^ ks_q[word_idx];
            out_last  <= in_last;
            out_valid <= 1'b1;
            word_idx  <= word_idx + 1'b1;
         end

         case (state)
            GEN: begin
               if (core_done) begin
                  ks_q       <= core_out;
                  word_idx   <= '0;
                  // Saturate instead of wrapping; last_blk_q remembers the final counter was used.
                  last_blk_q <= (ctr_q == '1);
                  if (ctr_q != '1) begin
                     ctr_q <= ctr_q + 1'b1;
                  end
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (accept) begin
                  if (in_last) begin
                     state <= IDLE;
                  end else if (word_idx == '1) begin
                     if (last_blk_q) begin
                        err   <= 1'b1;
                        state <= ERR;
                     end else begin
                        start_q <= 1'b1;
                        state   <= GEN;
                     end
                  end
               end
            end
            default: ;
         endcase

         if (cfg_take) begin
            key_q      <= key;
            nonce_q    <= nonce;
            ctr_q      <= counter_init;
            last_blk_q <= 1'b0;
            ks_q       <= '0;
            word_idx   <= '0;
            err        <= 1'b0;
            start_q    <= 1'b1;
            state      <= GEN;
         end
      end
   end

endmodule
